// File: rtl/stream_gather_bin_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_gather_bin_if
// Purpose  : Word-stream input / frame-vector output bundle of the gatherer.
// Revision : 1.0 - initial release
// ============================================================================
interface stream_gather_bin_if #(
  parameter int DATA_W = 13,
  parameter int DATA_N = 11
);
  localparam int CNT_W = $clog2(DATA_N + 1);

  logic                             s_valid;
  logic                             s_ready;
  logic [DATA_W-1:0]                s_data;
  logic                             s_last;
  logic                             m_valid;
  logic                             m_ready;
  logic [0:DATA_N-1][DATA_W-1:0]    m_data;
  logic [CNT_W-1:0]                 m_cnt;
  logic                             m_short;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_cnt, m_short
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_cnt, m_short
  );
endinterface
`default_nettype wire

// File: rtl/stream_gather_bin.sv
`default_nettype none
// ============================================================================
// Module   : stream_gather_bin
// Purpose  : Packs a word stream into zero-padded DATA_N-lane frames.
// Revision : 1.0 - initial release
// ============================================================================
module stream_gather_bin #(
  parameter int DATA_W = 13,
  parameter int DATA_N = 11
) (
  input  wire logic          clk,
  input  wire logic          rst,
  stream_gather_bin_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_N + 1);
  localparam logic [CNT_W-1:0] c_last_lane = CNT_W'(DATA_N - 1);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

  typedef logic [0:DATA_N-1][DATA_W-1:0] frame_t;

  frame_t           r_fill;
  frame_t           r_m_data;
  frame_t           w_frame;
  logic [CNT_W-1:0] r_fill_cnt;
  logic [CNT_W-1:0] r_m_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_pend;
  logic             r_pend_short;
  logic             r_m_valid;
  logic             r_m_short;
  logic             r_s_ready;
  logic             w_acc;
  logic             w_full;
  logic             w_close;
  logic             w_slot_free;
  logic             w_short;

  always_comb begin
    w_acc       = bus.s_valid & r_s_ready;
    w_full      = (r_fill_cnt == c_last_lane);
    w_close     = w_acc & (bus.s_last | w_full);
    w_slot_free = !r_m_valid | bus.m_ready;
    w_short     = !w_full;
    w_cnt_inc   = r_fill_cnt + c_one;
    // Unused lanes are already zero because the fill buffer is cleared per frame.
    w_frame     = r_fill;
    for (int i = 0; i < DATA_N; i++) begin
      if (CNT_W'(i) == r_fill_cnt) begin
        w_frame[i] = bus.s_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill       <= '0;
      r_fill_cnt   <= '0;
      r_pend       <= 1'b0;
      r_pend_short <= 1'b0;
      r_m_data     <= '0;
      r_m_cnt      <= '0;
      r_m_short    <= 1'b0;
      r_m_valid    <= 1'b0;
      r_s_ready    <= 1'b0;
    end else begin
      r_s_ready <= !r_pend;
      if (r_pend && w_slot_free) begin
        // Parked frame moves out; input side reopens next cycle.
        r_m_data   <= r_fill;
        r_m_cnt    <= r_fill_cnt;
        r_m_short  <= r_pend_short;
        r_m_valid  <= 1'b1;
        r_fill     <= '0;
        r_fill_cnt <= '0;
        r_pend     <= 1'b0;
        r_s_ready  <= 1'b1;
      end else if (w_close && w_slot_free) begin
        r_m_data   <= w_frame;
        r_m_cnt    <= w_cnt_inc;
        r_m_short  <= w_short;
        r_m_valid  <= 1'b1;
        r_fill     <= '0;
        r_fill_cnt <= '0;
      end else begin
        r_m_valid <= r_m_valid & !bus.m_ready;
        if (w_close) begin
          r_fill       <= w_frame;
          r_fill_cnt   <= w_cnt_inc;
          r_pend       <= 1'b1;
          r_pend_short <= w_short;
          r_s_ready    <= 1'b0;
        end else if (w_acc) begin
          r_fill     <= w_frame;
          r_fill_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign bus.s_ready = r_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;
  assign bus.m_cnt   = r_m_cnt;
  assign bus.m_short = r_m_short;
endmodule
`default_nettype wire

// File: tb/tb_stream_gather_bin.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_gather_bin
// Purpose  : Randomised and directed bench for stream_gather_bin with a frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_gather_bin;
  localparam int DATA_W = 13;
  localparam int DATA_N = 11;

  typedef logic [0:DATA_N-1][DATA_W-1:0] frame_t;
  typedef struct {
    frame_t d;
    int     cnt;
    bit     sh;
  } exp_t;

  logic clk;
  logic rst;
  bit   live;
  int   total_cnt;
  int   pass_cnt;

  exp_t              exp_q[$];
  exp_t              got_q[$];
  logic [DATA_W-1:0] part_q[$];

  stream_gather_bin_if #(.DATA_W(DATA_W), .DATA_N(DATA_N)) bus ();

  stream_gather_bin #(.DATA_W(DATA_W), .DATA_N(DATA_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
  endtask

  // Outputs are live only after a clock edge has passed with reset released.
  always @(posedge clk or posedge rst) begin
    if (rst) live <= 1'b0;
    else     live <= 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    bit   exp_ready;
    if (rst) begin
      exp_q.delete();
      part_q.delete();
      chk("rst_m_valid", 256'(bus.m_valid), 256'(0));
      chk("rst_s_ready", 256'(bus.s_ready), 256'(0));
    end else if (!live) begin
      chk("rel_m_valid", 256'(bus.m_valid), 256'(0));
    end else begin
      exp_ready = (exp_q.size() < 2);
      chk("s_ready", 256'(bus.s_ready), 256'(exp_ready));
      chk("m_valid", 256'(bus.m_valid), 256'(exp_q.size() > 0));
      if (bus.m_valid && exp_q.size() > 0) begin
        chk("m_data",  256'(bus.m_data),  256'(exp_q[0].d));
        chk("m_cnt",   256'(bus.m_cnt),   256'(exp_q[0].cnt));
        chk("m_short", 256'(bus.m_short), 256'(exp_q[0].sh));
        if (bus.m_ready) begin
          e.d = bus.m_data; e.cnt = int'(bus.m_cnt); e.sh = bus.m_short;
          got_q.push_back(e);
          void'(exp_q.pop_front());
        end
      end
      if (bus.s_valid && exp_ready) begin
        part_q.push_back(bus.s_data);
        if (bus.s_last || part_q.size() == DATA_N) begin
          e.d = '0;
          foreach (part_q[i]) e.d[i] = part_q[i];
          e.cnt = part_q.size();
          e.sh  = (part_q.size() < DATA_N);
          exp_q.push_back(e);
          part_q.delete();
        end
      end
    end
  end

  task automatic drive_beat(input logic [DATA_W-1:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = bus.s_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      total_cnt++;
      $display("FAIL beat_timeout: got no s_ready required s_ready=1 at %0t", $time);
    end
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int  base;
    bit  acc;
    total_cnt   = 0;
    pass_cnt    = 0;
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    #1;
    chk("reset_m_data",  256'(bus.m_data),  256'(0));
    chk("reset_m_cnt",   256'(bus.m_cnt),   256'(0));
    chk("reset_m_short", 256'(bus.m_short), 256'(0));
    chk("reset_s_ready", 256'(bus.s_ready), 256'(0));
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    bus.m_ready = 1'b1;
    @(posedge clk); #1;

    // Full frame 1..11
    base = got_q.size();
    for (int i = 1; i <= DATA_N; i++) drive_beat(DATA_W'(i), i == DATA_N);
    idle(4);
    chk("full_frames", 256'(got_q.size() - base), 256'(1));
    for (int i = 0; i < DATA_N; i++) chk("full_lane", 256'(got_q[base].d[i]), 256'(i + 1));
    chk("full_cnt",   256'(got_q[base].cnt), 256'(11));
    chk("full_short", 256'(got_q[base].sh),  256'(0));

    // Short frame -5, 7, -3
    base = got_q.size();
    drive_beat(-13'sd5, 1'b0);
    drive_beat(13'sd7, 1'b0);
    drive_beat(-13'sd3, 1'b1);
    idle(4);
    chk("short_lane0", 256'(got_q[base].d[0]), 256'(13'h1FFB));
    chk("short_lane1", 256'(got_q[base].d[1]), 256'(13'h0007));
    chk("short_lane2", 256'(got_q[base].d[2]), 256'(13'h1FFD));
    for (int i = 3; i < DATA_N; i++) chk("short_pad", 256'(got_q[base].d[i]), 256'(0));
    chk("short_cnt",   256'(got_q[base].cnt), 256'(3));
    chk("short_short", 256'(got_q[base].sh),  256'(1));

    // Back-to-back one-word frames
    base = got_q.size();
    for (int i = 0; i < 3; i++) drive_beat(DATA_W'(100 + i), 1'b1);
    idle(4);
    chk("single_frames", 256'(got_q.size() - base), 256'(3));
    for (int i = 0; i < 3; i++) begin
      chk("single_lane0", 256'(got_q[base + i].d[0]), 256'(100 + i));
      chk("single_cnt",   256'(got_q[base + i].cnt),  256'(1));
      chk("single_pad",   256'(got_q[base + i].d[1]), 256'(0));
    end

    // Streaming 33 words with no s_last
    base = got_q.size();
    for (int i = 0; i < 3 * DATA_N; i++) drive_beat(DATA_W'(300 + i), 1'b0);
    idle(4);
    chk("stream_frames", 256'(got_q.size() - base), 256'(3));
    for (int i = 0; i < 3; i++) chk("stream_cnt", 256'(got_q[base + i].cnt), 256'(11));

    // Backpressure: two full frames against a stalled output
    base = got_q.size();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 2 * DATA_N; i++) drive_beat(DATA_W'(600 + i), 1'b0);
    idle(3);
    @(negedge clk);
    chk("bp_s_ready_low", 256'(bus.s_ready), 256'(0));
    chk("bp_held_lane0",  256'(bus.m_data[0]), 256'(600));
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    @(negedge clk);
    chk("bp_second_lane0", 256'(bus.m_data[0]), 256'(611));
    chk("bp_s_ready_high", 256'(bus.s_ready), 256'(1));
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    idle(4);
    chk("bp_frames", 256'(got_q.size() - base), 256'(2));

    // Randomised traffic with random backpressure
    acc = 1'b0;
    bus.s_valid = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!bus.s_valid || acc) begin
        bus.s_valid = ($urandom_range(0, 3) != 0);
        bus.s_data  = DATA_W'($urandom);
        bus.s_last  = ($urandom_range(0, 5) == 0);
      end
      bus.m_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      @(posedge clk); #1;
    end
    bus.m_ready = 1'b1;
    drive_beat(DATA_W'(1), 1'b1);
    idle(6);
    chk("rand_drained", 256'(exp_q.size()), 256'(0));

    // Reset with a frame held and a short frame pending
    bus.m_ready = 1'b0;
    for (int i = 0; i < DATA_N; i++) drive_beat(DATA_W'(700 + i), 1'b0);
    for (int i = 0; i < 5; i++) drive_beat(DATA_W'(720 + i), i == 4);
    idle(2);
    base = got_q.size();
    #3 rst = 1'b1;
    #1;
    chk("async_m_valid", 256'(bus.m_valid), 256'(0));
    chk("async_s_ready", 256'(bus.s_ready), 256'(0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    idle(3);
    chk("post_rst_none", 256'(got_q.size() - base), 256'(0));
    for (int i = 0; i < 3; i++) drive_beat(DATA_W'(500 + i), i == 2);
    idle(4);
    chk("post_rst_frames", 256'(got_q.size() - base), 256'(1));
    chk("post_rst_lane0",  256'(got_q[base].d[0]), 256'(500));
    chk("post_rst_cnt",    256'(got_q[base].cnt),  256'(3));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
`default_nettype wire
